// File: rtl/acc_pkg.sv
// Shared op-codes, FSM states and flag bit positions for the accumulator unit
// and its sequential multiplier.
package acc_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LOAD = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_CLR  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_mul_seq.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle over WIDTH cycles.
// The final product is presented combinationally alongside 'last' so the caller can write it back on that edge.
module acc_mul_seq
  import acc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             last,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz
);

  localparam int CNTW = sel_width(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;

  assign prod_step  = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign last       = busy_q && (cnt_q == CNTW'(WIDTH - 1));
  assign busy       = busy_q;
  assign prod_lo    = prod_step[WIDTH-1:0];
  assign prod_hi_nz = |prod_step[2*WIDTH-1:WIDTH];

  always_comb begin
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      prod_d   = '0;
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      mcand_d  = mcand_q << 1;
      prod_d   = prod_step;
      mplier_d = mplier_q >> 1;
      cnt_d    = last ? '0 : cnt_q + CNTW'(1);
      busy_d   = !last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/acc_unit.sv
// Bank of NUM_ACC accumulators with a single-cycle ALU and an iterative multiplier.
// Every accepted op produces a one-cycle done pulse; writing ops also update {Z,N,C,V}.
module acc_unit
  import acc_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int NUM_ACC = 4,
  parameter  int SAT     = 0,
  localparam int SELW    = sel_width(NUM_ACC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [SELW-1:0]  op_sel,
  input  logic [SELW-1:0]  rd_sel,
  input  logic [WIDTH-1:0] op_data,
  output logic [WIDTH-1:0] acc_out,
  output logic             done,
  output logic [3:0]       flags
);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q [NUM_ACC];
  logic [3:0]       flags_q;
  logic             done_q;
  logic [SELW-1:0]  mul_sel_q;

  logic             accept, sel_ok, rd_ok, mul_start;
  logic             mul_busy, mul_last, mul_hi_nz;
  logic [WIDTH-1:0] mul_lo, cur, res;
  logic [WIDTH:0]   sum, diff;
  logic             wr_en, res_c, res_v;

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign op_ready  = (state_q == ST_IDLE) && !mul_busy;
  assign accept    = op_valid && op_ready;
  assign sel_ok    = (32'(op_sel) < NUM_ACC);
  assign rd_ok     = (32'(rd_sel) < NUM_ACC);
  assign cur       = sel_ok ? acc_q[op_sel] : '0;
  assign acc_out   = rd_ok ? acc_q[rd_sel] : '0;
  assign mul_start = accept && sel_ok && (op_code == OP_MUL);
  assign done      = done_q;
  assign flags     = flags_q;

  always_comb begin
    sum   = {1'b0, cur} + {1'b0, op_data};
    diff  = {1'b0, cur} - {1'b0, op_data};
    res   = cur;
    res_c = 1'b0;
    res_v = 1'b0;
    wr_en = 1'b0;
    if (accept && sel_ok) begin
      wr_en = 1'b1;
      case (op_code)
        OP_LOAD: res = op_data;
        OP_ADD: begin
          res   = sum[WIDTH-1:0];
          res_c = sum[WIDTH];
          res_v = (cur[WIDTH-1] == op_data[WIDTH-1]) && (sum[WIDTH-1] != cur[WIDTH-1]);
        end
        OP_SUB: begin
          res   = diff[WIDTH-1:0];
          res_c = diff[WIDTH];
          res_v = (cur[WIDTH-1] != op_data[WIDTH-1]) && (diff[WIDTH-1] != cur[WIDTH-1]);
        end
        OP_AND: res = cur & op_data;
        OP_OR:  res = cur | op_data;
        OP_XOR: res = cur ^ op_data;
        OP_CLR: res = '0;
        OP_SHL: begin
          res   = {cur[WIDTH-2:0], 1'b0};
          res_c = cur[WIDTH-1];
        end
        OP_SHR: begin
          res   = {1'b0, cur[WIDTH-1:1]};
          res_c = cur[0];
        end
        default: wr_en = 1'b0;
      endcase
      // Overflow direction follows the sign of the accumulator for both ADD and SUB.
      if ((SAT != 0) && res_v) begin
        res = cur[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end

  acc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (mul_start),
    .a          (cur),
    .b          (op_data),
    .busy       (mul_busy),
    .last       (mul_last),
    .prod_lo    (mul_lo),
    .prod_hi_nz (mul_hi_nz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      flags_q   <= '0;
      done_q    <= 1'b0;
      mul_sel_q <= '0;
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mul_start) begin
            state_q   <= ST_MUL_RUN;
            mul_sel_q <= op_sel;
          end else if (accept) begin
            done_q <= 1'b1;
            if (wr_en) begin
              acc_q[op_sel] <= res;
              flags_q       <= mk_flags(res, res_c, res_v);
            end
          end
        end
        ST_MUL_RUN: begin
          if (mul_last) begin
            acc_q[mul_sel_q] <= mul_lo;
            flags_q          <= mk_flags(mul_lo, mul_hi_nz, mul_hi_nz);
            done_q           <= 1'b1;
            state_q          <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
